// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the display scan controller.
// Combinational only; no latency and no flow control.
// The blank symbol code is the arranger's space glyph.
package disp_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [5:0] DISP_BLANK = 6'h3F;

    typedef logic [2:0] scan_idx_t;
    localparam scan_idx_t LAST_DIGIT = 3'd7;

    function automatic int clk_div(input int num, input int den);
        return (num / den < 1) ? 1 : num / den;
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_tick.sv
// Free-running divider producing a one-cycle tick at count DIV-1.
// Combinational tick, registered count; holds its count while en_i=0, no backpressure.
module tick_gen
    import disp_scan_ctrl_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan index generator with double-buffered, blink-masked digit codes for the arranger.
// Outputs registered, 1 cycle after their source; load is always accepted, never stalls.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int BLINK_HZ = 2,
    parameter int CODE_W   = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           load,
    input  logic [NUM_DIGITS*CODE_W-1:0]   dat_in,
    input  logic [NUM_DIGITS-1:0]          blink_mask,
    output logic [2:0]                     disp_bit,
    output logic [CODE_W-1:0]              disp_dat0,
    output logic [CODE_W-1:0]              disp_dat1,
    output logic [CODE_W-1:0]              disp_dat2,
    output logic [CODE_W-1:0]              disp_dat3,
    output logic [CODE_W-1:0]              disp_dat4,
    output logic [CODE_W-1:0]              disp_dat5,
    output logic [CODE_W-1:0]              disp_dat6,
    output logic [CODE_W-1:0]              disp_dat7,
    output logic                           frame_done
);

    localparam int SDIV = clk_div(CLK_HZ, SCAN_HZ);
    localparam int BDIV = clk_div(CLK_HZ, 2 * BLINK_HZ);
    localparam logic [CODE_W-1:0] BLANK = CODE_W'(DISP_BLANK);

    logic scan_tick, blink_tick, commit;

    scan_idx_t         disp_bit_q, disp_bit_d;
    logic              frame_done_q;
    logic              blink_phase_q;
    logic              pending_vld_q, pending_vld_d;
    logic [CODE_W-1:0] pending_q  [NUM_DIGITS];
    logic [CODE_W-1:0] pending_d  [NUM_DIGITS];
    logic [CODE_W-1:0] active_q   [NUM_DIGITS];
    logic [CODE_W-1:0] active_d   [NUM_DIGITS];
    logic [CODE_W-1:0] disp_dat_q [NUM_DIGITS];
    logic [CODE_W-1:0] disp_dat_d [NUM_DIGITS];

    tick_gen #(.DIV(SDIV)) u_scan_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (enable),
        .tick_o (scan_tick)
    );

    tick_gen #(.DIV(BDIV)) u_blink_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (enable),
        .tick_o (blink_tick)
    );

    // Frames swap only on the 7->0 step so the arranger never shows a mixed frame.
    assign commit = scan_tick && (disp_bit_q == LAST_DIGIT);

    always_comb begin
        disp_bit_d    = scan_tick ? disp_bit_q + 3'd1 : disp_bit_q;
        pending_vld_d = pending_vld_q;
        if (commit) begin
            pending_vld_d = 1'b0;
        end else if (load) begin
            pending_vld_d = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pending_d[i] = pending_q[i];
            active_d[i]  = active_q[i];
            if (load && !commit) begin
                pending_d[i] = dat_in[i*CODE_W +: CODE_W];
            end
            if (commit && load) begin
                active_d[i] = dat_in[i*CODE_W +: CODE_W];
            end else if (commit && pending_vld_q) begin
                active_d[i] = pending_q[i];
            end
            disp_dat_d[i] = (!enable || (blink_mask[i] && !blink_phase_q)) ? BLANK : active_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bit_q    <= '0;
            frame_done_q  <= 1'b0;
            blink_phase_q <= 1'b1;
            pending_vld_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pending_q[i]  <= '0;
                active_q[i]   <= BLANK;
                disp_dat_q[i] <= BLANK;
            end
        end else begin
            disp_bit_q    <= disp_bit_d;
            frame_done_q  <= commit;
            blink_phase_q <= blink_tick ? ~blink_phase_q : blink_phase_q;
            pending_vld_q <= pending_vld_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pending_q[i]  <= pending_d[i];
                active_q[i]   <= active_d[i];
                disp_dat_q[i] <= disp_dat_d[i];
            end
        end
    end

    assign disp_bit   = disp_bit_q;
    assign frame_done = frame_done_q;
    assign disp_dat0  = disp_dat_q[0];
    assign disp_dat1  = disp_dat_q[1];
    assign disp_dat2  = disp_dat_q[2];
    assign disp_dat3  = disp_dat_q[3];
    assign disp_dat4  = disp_dat_q[4];
    assign disp_dat5  = disp_dat_q[5];
    assign disp_dat6  = disp_dat_q[6];
    assign disp_dat7  = disp_dat_q[7];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: phase table with hand-derived end values, hand sequences
// for the corner cases, then random stimulus, all checked every cycle against a model.
module tb_disp_scan_ctrl;

    localparam int SDIV  = 4;
    localparam int BDIV  = 16;
    localparam int FRAME = 8 * SDIV;
    localparam logic [5:0] BLK = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [47:0] dat_in;
    logic [7:0]  blink_mask;
    logic [2:0]  disp_bit;
    logic [5:0]  dd [8];
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    disp_scan_ctrl #(
        .CLK_HZ   (64),
        .SCAN_HZ  (16),
        .BLINK_HZ (2),
        .CODE_W   (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .dat_in     (dat_in),
        .blink_mask (blink_mask),
        .disp_bit   (disp_bit),
        .disp_dat0  (dd[0]),
        .disp_dat1  (dd[1]),
        .disp_dat2  (dd[2]),
        .disp_dat3  (dd[3]),
        .disp_dat4  (dd[4]),
        .disp_dat5  (dd[5]),
        .disp_dat6  (dd[6]),
        .disp_dat7  (dd[7]),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Model state: e counts enabled cycles since reset; index and blink phase follow from it.
    int         me;
    logic [5:0] mact  [8];
    logic [5:0] mpend [8];
    bit         mpvld;
    logic [5:0] mout  [8];
    bit         mfd;

    task automatic model_reset();
        me = 0; mpvld = 0; mfd = 0;
        for (int i = 0; i < 8; i++) begin
            mact[i] = BLK; mpend[i] = '0; mout[i] = BLK;
        end
    endtask

    task automatic model_step(input bit en, input bit ld, input logic [47:0] d, input logic [7:0] m);
        bit commit;
        bit blank_half;
        commit     = en && ((me % FRAME) == FRAME - 1);
        blank_half = ((me / BDIV) % 2) == 1;
        for (int i = 0; i < 8; i++)
            mout[i] = (!en || (m[i] && blank_half)) ? BLK : mact[i];
        mfd = commit;
        if (ld && commit) begin
            for (int i = 0; i < 8; i++) mact[i] = d[i*6 +: 6];
            mpvld = 0;
        end else if (ld) begin
            for (int i = 0; i < 8; i++) mpend[i] = d[i*6 +: 6];
            mpvld = 1;
        end else if (commit && mpvld) begin
            for (int i = 0; i < 8; i++) mact[i] = mpend[i];
            mpvld = 0;
        end
        if (en) me++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit en, input bit ld, input logic [47:0] d, input logic [7:0] m);
        enable = en; load = ld; dat_in = d; blink_mask = m;
        model_step(en, ld, d, m);
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("bit", int'(disp_bit), (me / SDIV) % 8);
        chk("frame_done", int'(frame_done), int'(mfd));
        for (int i = 0; i < 8; i++) chk($sformatf("dat%0d", i), int'(dd[i]), int'(mout[i]));
    endtask

    function automatic logic [47:0] fill(input int code);
        logic [47:0] r;
        for (int i = 0; i < 8; i++) r[i*6 +: 6] = 6'(code);
        return r;
    endfunction

    function automatic logic [47:0] ramp();
        logic [47:0] r;
        for (int i = 0; i < 8; i++) r[i*6 +: 6] = 6'(i + 1);
        return r;
    endfunction

    typedef struct {
        int          cycles;
        bit          en;
        bit          ld;
        logic [47:0] dat;
        logic [7:0]  mask;
        int          exp_bit;
        int          exp_d0;
        int          exp_d1;
        int          exp_d7;
        int          exp_fd;
    } vec_t;

    vec_t vec [11];

    task automatic check_reset_state(input string tag);
        chk({tag, "_bit"}, int'(disp_bit), 0);
        chk({tag, "_fd"}, int'(frame_done), 0);
        chk({tag, "_pvld"}, int'(dut.pending_vld_q), 0);
        chk({tag, "_phase"}, int'(dut.blink_phase_q), 1);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_dat%0d", tag, i), int'(dd[i]), int'(BLK));
    endtask

    initial begin
        //         cycles en ld dat       mask   bit d0   d1   d7   fd
        vec[0]  = '{8,  1, 0, fill(0), 8'h00, 2, BLK, BLK, BLK, 0};
        vec[1]  = '{10, 1, 1, ramp(),  8'h00, 4, BLK, BLK, BLK, 0};
        vec[2]  = '{16, 1, 0, fill(0), 8'h00, 0, 1,   2,   8,   0};
        vec[3]  = '{10, 1, 1, fill(5), 8'h00, 3, 1,   2,   8,   0};
        vec[4]  = '{30, 1, 1, fill(9), 8'h00, 2, 9,   9,   9,   0};
        vec[5]  = '{30, 1, 1, fill(3), 8'h81, 2, 3,   3,   3,   0};
        vec[6]  = '{13, 1, 0, fill(0), 8'h81, 5, BLK, 3,   BLK, 0};
        vec[7]  = '{10, 0, 0, fill(0), 8'h81, 5, BLK, BLK, BLK, 0};
        vec[8]  = '{2,  1, 0, fill(0), 8'h00, 5, 3,   3,   3,   0};
        vec[9]  = '{1,  1, 0, fill(0), 8'h00, 6, 3,   3,   3,   0};
        vec[10] = '{8,  1, 0, fill(0), 8'h00, 0, 3,   3,   3,   1};

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; dat_in = '0; blink_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            for (int c = 0; c < vec[v].cycles; c++)
                cyc(vec[v].en, vec[v].ld && (c == 0), vec[v].dat, vec[v].mask);
            chk($sformatf("vec%0d_bit", v), int'(disp_bit), vec[v].exp_bit);
            chk($sformatf("vec%0d_d0", v), int'(dd[0]), vec[v].exp_d0);
            chk($sformatf("vec%0d_d1", v), int'(dd[1]), vec[v].exp_d1);
            chk($sformatf("vec%0d_d7", v), int'(dd[7]), vec[v].exp_d7);
            chk($sformatf("vec%0d_fd", v), int'(frame_done), vec[v].exp_fd);
        end

        // Load landing on the commit cycle overrides an older pending frame.
        for (int k = 0; k < 2 * FRAME && (me % FRAME) != FRAME - 1; k++)
            cyc(1, k == 0, fill(4), 8'h00);
        chk("coinc_reached", me % FRAME, FRAME - 1);
        cyc(1, 1, fill(7), 8'h00);
        chk("coinc_pvld", int'(dut.pending_vld_q), 0);
        chk("coinc_fd", int'(frame_done), 1);
        cyc(1, 0, fill(0), 8'h00);
        chk("coinc_d0", int'(dd[0]), 7);
        chk("coinc_d5", int'(dd[5]), 7);

        begin
            logic [63:0] r64;
            logic [7:0]  m;
            m = '0;
            for (int n = 0; n < 2000; n++) begin
                r64 = {$urandom, $urandom};
                if (n % 20 == 0) m = 8'($urandom_range(0, 255));
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, r64[47:0], m);
            end
        end

        // Asynchronous reset mid-frame with a pending frame that must be lost.
        cyc(1, 1, fill(2), 8'h00);
        cyc(1, 0, fill(0), 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) cyc(1, 0, fill(0), 8'h00);
        chk("post_rst_d0", int'(dd[0]), int'(BLK));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
